// File: rtl/spidergon_pkg.sv
// Shared Spidergon definitions used by the network interface and the node router.
// Contents:
//   - flit type codes and first-hop port codes
//   - field widths (HEAD_TAIL, DIRECTION_WIDTH, NUM_OF_PORTS)
//   - helpers giving the MSB of each head-flit field
//   - NI transmit FSM state encoding
package spidergon_pkg;

    localparam int HEAD_TAIL       = 2;  // width of the flit type field
    localparam int DIRECTION_WIDTH = 2;  // width of a port code
    localparam int NUM_OF_PORTS    = 3;  // ring-facing ports: anti-clockwise, clockwise, across

    typedef enum logic [1:0] {
        FLIT_TAIL   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_BODY   = 2'b10,
        FLIT_HEADER = 2'b11
    } flit_type_e;

    localparam logic [1:0] ANTI_CLOCKWISE = 2'd0;
    localparam logic [1:0] CLOCKWISE      = 2'd1;
    localparam logic [1:0] ACROSS         = 2'd2;
    localparam logic [1:0] STOP           = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALLOC = 2'd1,
        ST_BODY  = 2'd2,
        ST_DRAIN = 2'd3
    } ni_state_e;

    // Head data field layout, MSB first: {vc, dest, src, zero pad}
    function automatic int head_vc_msb(input int fdw);
        return fdw - 1;
    endfunction

    function automatic int head_dest_msb(input int fdw, input int vcw);
        return fdw - 1 - vcw;
    endfunction

    function automatic int head_src_msb(input int fdw, input int vcw, input int dw);
        return fdw - 1 - vcw - dw;
    endfunction

endpackage

// File: rtl/spidergon_route_compute.sv
// Combinational first-hop routing for a Spidergon ring.
// Ports:
//   src_i  : source node index
//   dest_i : destination node index
//   port_o : first-hop port (ANTI_CLOCKWISE / CLOCKWISE / ACROSS, STOP when self-addressed)
//   self_o : destination equals source
module spidergon_route_compute
    import spidergon_pkg::*;
#(
    parameter  int NUM_OF_NODES = 8,
    localparam int DW           = $clog2(NUM_OF_NODES)
) (
    input  logic [DW-1:0]              src_i,
    input  logic [DW-1:0]              dest_i,
    output logic [DIRECTION_WIDTH-1:0] port_o,
    output logic                       self_o
);

    localparam logic [DW:0] N_W   = (DW+1)'(NUM_OF_NODES);
    localparam logic [DW:0] QTR_W = (DW+1)'(NUM_OF_NODES / 4);

    logic [DW:0] sum_s;
    logic [DW:0] rel_s;

    // Relative distance (dest - src) mod N; adding N first keeps it non-negative for any ring size
    always_comb begin
        sum_s = {1'b0, dest_i} + N_W - {1'b0, src_i};
        if (sum_s >= N_W) begin
            rel_s = sum_s - N_W;
        end else begin
            rel_s = sum_s;
        end
    end

    // Quarter ring either way goes around the ring, everything else crosses
    always_comb begin
        self_o = 1'b0;
        port_o = ACROSS;
        if (rel_s == {(DW+1){1'b0}}) begin
            self_o = 1'b1;
            port_o = STOP;
        end else if (rel_s <= QTR_W) begin
            port_o = CLOCKWISE;
        end else if (rel_s >= N_W - QTR_W) begin
            port_o = ANTI_CLOCKWISE;
        end else begin
            port_o = ACROSS;
        end
    end

endmodule

// File: rtl/spidergon_ni_packetizer.sv
// Network-interface transmitter: turns (dest, len) requests plus a payload word
// stream into HEAD/BODY/TAIL flits (single HEADER flit for empty messages) for the
// local input of one Spidergon node, with VC allocation and ON/OFF flow control.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   req_valid_i/req_ready_o         : request handshake; req_dest_i, req_len_i request fields
//   req_err_o                       : one-cycle pulse for a self-addressed request
//   word_valid_i/word_ready_o       : payload handshake; word_data_i payload word
//   port_vc_ready_i, port_vc_full_i : per port/VC downstream status, index port*VC+vc
//   flit_out_o                      : registered flit {type, data}; zero when not valid
//   flit_out_valid_o                : one cycle per flit
//   flit_out_port_o, flit_out_vc_o  : first-hop port and VC of the flit
module spidergon_ni_packetizer
    import spidergon_pkg::*;
#(
    parameter  int NUM_OF_NODES            = 8,
    parameter  int FLIT_DATA_WIDTH         = 16,
    parameter  int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter  int NODE_IDENTIFIER         = 0,
    parameter  int MAX_PKT_WORDS           = 15,
    localparam int DW  = $clog2(NUM_OF_NODES),
    localparam int VCW = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1,
    localparam int LW  = $clog2(MAX_PKT_WORDS + 1),
    localparam int FLIT_TOTAL_WIDTH = FLIT_DATA_WIDTH + HEAD_TAIL,
    localparam int PVW = NUM_OF_PORTS * NUM_OF_VIRTUAL_CHANNELS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [DW-1:0]               req_dest_i,
    input  logic [LW-1:0]               req_len_i,
    output logic                        req_err_o,
    input  logic                        word_valid_i,
    output logic                        word_ready_o,
    input  logic [FLIT_DATA_WIDTH-1:0]  word_data_i,
    input  logic [PVW-1:0]              port_vc_ready_i,
    input  logic [PVW-1:0]              port_vc_full_i,
    output logic [FLIT_TOTAL_WIDTH-1:0] flit_out_o,
    output logic                        flit_out_valid_o,
    output logic [DIRECTION_WIDTH-1:0]  flit_out_port_o,
    output logic [VCW-1:0]              flit_out_vc_o
);

    localparam int NV       = NUM_OF_VIRTUAL_CHANNELS;
    localparam int FDW      = FLIT_DATA_WIDTH;
    localparam int VC_MSB   = head_vc_msb(FDW);
    localparam int DEST_MSB = head_dest_msb(FDW, VCW);
    localparam int SRC_MSB  = head_src_msb(FDW, VCW, DW);
    localparam logic [DW-1:0] SRC = DW'(NODE_IDENTIFIER);

    ni_state_e                     state_q, state_d;
    logic [DW-1:0]                 dest_q, dest_d;
    logic [DIRECTION_WIDTH-1:0]    port_q, port_d;
    logic [VCW-1:0]                vc_q, vc_d;
    logic [LW-1:0]                 rem_q, rem_d;
    logic                          req_err_q, req_err_d;
    logic [FLIT_TOTAL_WIDTH-1:0]   flit_q, flit_d;
    logic                          flit_valid_q, flit_valid_d;
    logic [DIRECTION_WIDTH-1:0]    flit_port_q, flit_port_d;
    logic [VCW-1:0]                flit_vc_q, flit_vc_d;

    logic [DIRECTION_WIDTH-1:0]    route_port_s;
    logic                          route_self_s;
    logic [NV-1:0]                 port_ready_s;
    logic [NV-1:0]                 port_full_s;
    logic                          vc_found_s;
    logic [VCW-1:0]                vc_pick_s;
    logic [FDW-1:0]                head_data_s;
    flit_type_e                    body_type_s;
    logic                          req_ready_s;
    logic                          word_ready_s;
    logic                          word_fire_s;

    spidergon_route_compute #(
        .NUM_OF_NODES (NUM_OF_NODES)
    ) u_route (
        .src_i  (SRC),
        .dest_i (req_dest_i),
        .port_o (route_port_s),
        .self_o (route_self_s)
    );

    // Select the ready/full vectors of the packet's latched port
    always_comb begin
        case (port_q)
            ANTI_CLOCKWISE: begin
                port_ready_s = port_vc_ready_i[NV*0 +: NV];
                port_full_s  = port_vc_full_i[NV*0 +: NV];
            end
            CLOCKWISE: begin
                port_ready_s = port_vc_ready_i[NV*1 +: NV];
                port_full_s  = port_vc_full_i[NV*1 +: NV];
            end
            ACROSS: begin
                port_ready_s = port_vc_ready_i[NV*2 +: NV];
                port_full_s  = port_vc_full_i[NV*2 +: NV];
            end
            default: begin
                port_ready_s = {NV{1'b0}};
                port_full_s  = {NV{1'b0}};
            end
        endcase
    end

    // Fixed-priority VC picker; scanning downward lets the lowest usable index win
    always_comb begin
        vc_found_s = 1'b0;
        vc_pick_s  = {VCW{1'b0}};
        for (int v = NV - 1; v >= 0; v--) begin
            if (port_ready_s[v] && !port_full_s[v]) begin
                vc_found_s = 1'b1;
                vc_pick_s  = VCW'(v);
            end else begin
                vc_found_s = vc_found_s;
            end
        end
    end

    // Head payload built from the VC being allocated this cycle
    always_comb begin
        head_data_s                    = {FDW{1'b0}};
        head_data_s[VC_MSB -: VCW]     = vc_pick_s;
        head_data_s[DEST_MSB -: DW]    = dest_q;
        head_data_s[SRC_MSB -: DW]     = SRC;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (!route_self_s) begin
                        state_d = ST_ALLOC;
                    end else if (req_len_i == {LW{1'b0}}) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALLOC: begin
                if (!vc_found_s) begin
                    state_d = ST_ALLOC;
                end else if (rem_q == {LW{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BODY;
                end
            end
            ST_BODY, ST_DRAIN: begin
                if (rem_q == {LW{1'b0}}) begin
                    state_d = ST_IDLE;
                end else if (word_fire_s && rem_q == LW'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; body words stall only on the allocated VC being full
    always_comb begin
        req_ready_s  = 1'b0;
        word_ready_s = 1'b0;
        case (state_q)
            ST_IDLE:  req_ready_s  = 1'b1;
            ST_ALLOC: word_ready_s = 1'b0;
            ST_BODY:  word_ready_s = !port_full_s[vc_q];
            ST_DRAIN: word_ready_s = 1'b1;
            default:  word_ready_s = 1'b0;
        endcase
    end

    assign word_fire_s  = word_valid_i & word_ready_s;
    assign req_ready_o  = req_ready_s;
    assign word_ready_o = word_ready_s;

    // Datapath next values: request latch, remaining-word counter, flit staging
    always_comb begin
        dest_d       = dest_q;
        port_d       = port_q;
        vc_d         = vc_q;
        rem_d        = rem_q;
        req_err_d    = 1'b0;
        flit_d       = {FLIT_TOTAL_WIDTH{1'b0}};
        flit_valid_d = 1'b0;
        flit_port_d  = flit_port_q;
        flit_vc_d    = flit_vc_q;
        body_type_s  = (rem_q == LW'(1)) ? FLIT_TAIL : FLIT_BODY;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    dest_d    = req_dest_i;
                    port_d    = route_port_s;
                    rem_d     = req_len_i;
                    req_err_d = route_self_s;
                end else begin
                    rem_d = rem_q;
                end
            end
            ST_ALLOC: begin
                if (vc_found_s) begin
                    vc_d         = vc_pick_s;
                    flit_valid_d = 1'b1;
                    flit_d       = {(rem_q == {LW{1'b0}}) ? FLIT_HEADER : FLIT_HEAD, head_data_s};
                    flit_port_d  = port_q;
                    flit_vc_d    = vc_pick_s;
                end else begin
                    vc_d = vc_q;
                end
            end
            ST_BODY: begin
                if (word_fire_s && rem_q != {LW{1'b0}}) begin
                    flit_valid_d = 1'b1;
                    flit_d       = {body_type_s, word_data_i};
                    flit_port_d  = port_q;
                    flit_vc_d    = vc_q;
                    rem_d        = rem_q - LW'(1);
                end else begin
                    rem_d = rem_q;
                end
            end
            ST_DRAIN: begin
                if (word_fire_s && rem_q != {LW{1'b0}}) begin
                    rem_d = rem_q - LW'(1);
                end else begin
                    rem_d = rem_q;
                end
            end
            default: rem_d = {LW{1'b0}};
        endcase
    end

    // Datapath and output registers; reset drops any packet in flight without a tail
    always_ff @(posedge clk) begin
        if (reset) begin
            dest_q       <= {DW{1'b0}};
            port_q       <= ANTI_CLOCKWISE;
            vc_q         <= {VCW{1'b0}};
            rem_q        <= {LW{1'b0}};
            req_err_q    <= 1'b0;
            flit_q       <= {FLIT_TOTAL_WIDTH{1'b0}};
            flit_valid_q <= 1'b0;
            flit_port_q  <= ANTI_CLOCKWISE;
            flit_vc_q    <= {VCW{1'b0}};
        end else begin
            dest_q       <= dest_d;
            port_q       <= port_d;
            vc_q         <= vc_d;
            rem_q        <= rem_d;
            req_err_q    <= req_err_d;
            flit_q       <= flit_d;
            flit_valid_q <= flit_valid_d;
            flit_port_q  <= flit_port_d;
            flit_vc_q    <= flit_vc_d;
        end
    end

    assign req_err_o        = req_err_q;
    assign flit_out_o       = flit_q;
    assign flit_out_valid_o = flit_valid_q;
    assign flit_out_port_o  = flit_port_q;
    assign flit_out_vc_o    = flit_vc_q;

endmodule

// File: tb/tb_spidergon_ni_packetizer.sv
// Self-checking bench for spidergon_ni_packetizer: directed scenarios followed by
// randomized messages, each compared against an expected flit list built from the
// routing/VC/flit-format rules.
module tb_spidergon_ni_packetizer;

    localparam int N    = 8;
    localparam int FDW  = 16;
    localparam int NV   = 2;
    localparam int NODE = 0;
    localparam int MAXW = 15;
    localparam int DW   = 3;
    localparam int VCW  = 1;
    localparam int LW   = 4;
    localparam int FTW  = FDW + 2;
    localparam int PVW  = 3 * NV;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [DW-1:0]   req_dest_i;
    logic [LW-1:0]   req_len_i;
    logic            req_err_o;
    logic            word_valid_i;
    logic            word_ready_o;
    logic [FDW-1:0]  word_data_i;
    logic [PVW-1:0]  port_vc_ready_i;
    logic [PVW-1:0]  port_vc_full_i;
    logic [FTW-1:0]  flit_out_o;
    logic            flit_out_valid_o;
    logic [1:0]      flit_out_port_o;
    logic [VCW-1:0]  flit_out_vc_o;

    always #5 clk = ~clk;

    spidergon_ni_packetizer #(
        .NUM_OF_NODES            (N),
        .FLIT_DATA_WIDTH         (FDW),
        .NUM_OF_VIRTUAL_CHANNELS (NV),
        .NODE_IDENTIFIER         (NODE),
        .MAX_PKT_WORDS           (MAXW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_dest_i       (req_dest_i),
        .req_len_i        (req_len_i),
        .req_err_o        (req_err_o),
        .word_valid_i     (word_valid_i),
        .word_ready_o     (word_ready_o),
        .word_data_i      (word_data_i),
        .port_vc_ready_i  (port_vc_ready_i),
        .port_vc_full_i   (port_vc_full_i),
        .flit_out_o       (flit_out_o),
        .flit_out_valid_o (flit_out_valid_o),
        .flit_out_port_o  (flit_out_port_o),
        .flit_out_vc_o    (flit_out_vc_o)
    );

    int             n_pass  = 0;
    int             n_total = 0;
    logic [FDW-1:0] words [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference routing: 3 means self-addressed
    function automatic int route_port(input int dest);
        int rel;
        rel = (dest - NODE + N) % N;
        if (rel == 0) return 3;
        if (rel <= N / 4) return 1;
        if (rel >= N - N / 4) return 0;
        return 2;
    endfunction

    function automatic logic [63:0] pack(input logic [1:0] t, input logic [FDW-1:0] d,
                                         input logic [1:0] p, input logic [VCW-1:0] v);
        return 64'({t, d, p, v});
    endfunction

    // Runs one message from request to completion; called at posedge+1 with the DUT idle
    task automatic run_pkt(input int dest, input int len, input logic [PVW-1:0] rdy,
                           input logic [PVW-1:0] ful, input int p_wv, input int p_full,
                           input int noavail, input int force_full, input bit consecutive);
        int             ep;
        int             ev;
        bit             self;
        bit             found;
        logic [FDW-1:0] hd;
        logic [63:0]    expq[$];
        logic [63:0]    obsq[$];
        int             cyc, consumed, errs, quiet, hs_cnt, first_c, last_c;
        bit             taken, head_seen, zero_ok, fullv, wrv, prev_full;
        ep = route_port(dest);
        self = (ep == 3);
        ev = 0; found = 1'b0;
        if (!self) begin
            for (int v = 0; v < NV; v++) begin
                if (!found && rdy[ep*NV+v] && !ful[ep*NV+v]) begin
                    ev = v; found = 1'b1;
                end
            end
            hd = (FDW'(ev) << (FDW - VCW)) | (FDW'(dest) << (FDW - VCW - DW))
               | (FDW'(NODE) << (FDW - VCW - 2*DW));
            expq.push_back(pack((len == 0) ? 2'b11 : 2'b01, hd, 2'(ep), VCW'(ev)));
            for (int i = 0; i < len; i++)
                expq.push_back(pack((i == len - 1) ? 2'b00 : 2'b10, words[i], 2'(ep), VCW'(ev)));
        end
        cyc = 0; consumed = 0; errs = 0; quiet = 0; hs_cnt = 0; first_c = -1; last_c = -1;
        taken = 0; head_seen = 0; zero_ok = 1; fullv = 0; wrv = 0; prev_full = 0;
        req_valid_i     = 1'b1;
        req_dest_i      = DW'(dest);
        req_len_i       = LW'(len);
        word_valid_i    = ($urandom_range(0, 99) < p_wv);
        word_data_i     = words[0];
        port_vc_ready_i = (noavail > 0) ? '0 : rdy;
        port_vc_full_i  = ful;
        while (cyc < 400) begin
            @(negedge clk);
            if (flit_out_valid_o) begin
                obsq.push_back(pack(flit_out_o[FTW-1:FDW], flit_out_o[FDW-1:0], flit_out_port_o, flit_out_vc_o));
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                if (prev_full) fullv = 1;
                head_seen = 1;
            end else if (flit_out_o !== '0) begin
                zero_ok = 0;
            end
            if (req_err_o) errs++;
            if (head_seen && !self && port_vc_full_i[ep*NV+ev] && word_ready_o) wrv = 1;
            prev_full = head_seen && !self && port_vc_full_i[ep*NV+ev];
            if (req_valid_i && req_ready_o) taken = 1;
            if (word_valid_i && word_ready_o) consumed++;
            if (taken && consumed == len && obsq.size() >= expq.size()) quiet++;
            if (quiet >= 3) break;
            @(posedge clk); #1;
            cyc++;
            if (taken) req_valid_i = 1'b0;
            word_valid_i = ($urandom_range(0, 99) < p_wv);
            word_data_i  = (consumed < 16) ? words[consumed] : FDW'($urandom());
            port_vc_ready_i = (cyc <= noavail) ? '0 : rdy;
            if (head_seen && !self) begin
                if (hs_cnt < force_full) begin
                    port_vc_full_i = '1;
                end else begin
                    for (int b = 0; b < PVW; b++) port_vc_full_i[b] = ($urandom_range(0, 99) < p_full);
                end
                hs_cnt++;
            end else begin
                port_vc_full_i = ful;
            end
        end
        check("timeout", 64'(cyc < 400), 64'(1));
        check("flit_count", 64'(obsq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) check("flit", obsq[i], expq[i]);
        check("req_err_pulses", 64'(errs), 64'(self ? 1 : 0));
        check("words_consumed", 64'(consumed), 64'(len));
        check("zero_when_idle", 64'(zero_ok), 64'(1));
        check("flit_while_full", 64'(fullv), 64'(0));
        check("word_ready_while_full", 64'(wrv), 64'(0));
        if (consecutive) check("flit_span", 64'(last_c - first_c), 64'(len));
        check("req_ready_after", 64'(req_ready_o), 64'(1));
        req_valid_i     = 1'b0;
        word_valid_i    = 1'b0;
        port_vc_ready_i = '1;
        port_vc_full_i  = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        int             d, l, ep, v, nf;
        logic [PVW-1:0] rdy, ful;

        reset = 1'b1; req_valid_i = 1'b0; req_dest_i = '0; req_len_i = '0;
        word_valid_i = 1'b1; word_data_i = 16'h1234;
        port_vc_ready_i = '1; port_vc_full_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready_o), 64'(1));
        check("rst_flit_valid", 64'(flit_out_valid_o), 64'(0));
        check("rst_flit", 64'(flit_out_o), 64'(0));
        check("rst_req_err", 64'(req_err_o), 64'(0));
        check("rst_word_ready", 64'(word_ready_o), 64'(0));
        check("rst_port_vc", 64'({flit_out_port_o, flit_out_vc_o}), 64'(0));
        reset = 1'b0; word_valid_i = 1'b0;
        @(posedge clk); #1;

        // Empty message to a clockwise neighbour: single HEADER flit
        run_pkt(1, 0, '1, '0, 100, 0, 0, 0, 1);

        // Three-word message across the ring, back to back
        words[0] = 16'h00A1; words[1] = 16'h00B2; words[2] = 16'h00C3;
        run_pkt(4, 3, '1, '0, 100, 0, 0, 0, 1);

        // Anti-clockwise with vc0 not ready: whole packet on vc1
        for (int i = 0; i < 16; i++) words[i] = FDW'($urandom());
        run_pkt(7, 4, 6'b111110, '0, 100, 0, 0, 0, 1);

        // Full held for three cycles mid-packet, plus a VC-less allocation wait
        for (int i = 0; i < 16; i++) words[i] = FDW'($urandom());
        run_pkt(4, 3, '1, '0, 100, 0, 0, 3, 0);
        run_pkt(2, 2, '1, '0, 100, 0, 3, 0, 0);

        // Self-addressed message is drained
        run_pkt(0, 2, '1, '0, 100, 0, 0, 0, 0);

        // Reset in the middle of a body
        for (int i = 0; i < 16; i++) words[i] = FDW'($urandom());
        req_valid_i = 1'b1; req_dest_i = 3'd4; req_len_i = 4'd5;
        word_valid_i = 1'b1; word_data_i = words[0];
        nf = 0;
        for (int c = 0; c < 30 && nf < 2; c++) begin
            @(negedge clk);
            if (flit_out_valid_o) nf++;
            if (req_valid_i && req_ready_o) begin
                @(posedge clk); #1;
                req_valid_i = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        check("pre_reset_flits", 64'(nf), 64'(2));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_flit_valid", 64'(flit_out_valid_o), 64'(0));
        check("midrst_req_ready", 64'(req_ready_o), 64'(1));
        check("midrst_word_ready", 64'(word_ready_o), 64'(0));
        reset = 1'b0; word_valid_i = 1'b0;
        @(posedge clk); #1;
        run_pkt(5, 3, '1, '0, 80, 20, 0, 0, 0);

        // Randomized messages
        for (int k = 0; k < 24; k++) begin
            d = $urandom_range(0, N - 1);
            l = $urandom_range(0, MAXW);
            for (int i = 0; i < 16; i++) words[i] = FDW'($urandom());
            rdy = PVW'($urandom());
            ful = PVW'($urandom());
            ep = route_port(d);
            if (ep != 3) begin
                v = $urandom_range(0, NV - 1);
                rdy[ep*NV+v] = 1'b1;
                ful[ep*NV+v] = 1'b0;
            end
            run_pkt(d, l, rdy, ful, 70, 30, $urandom_range(0, 2), $urandom_range(0, 2), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
